icache_fill_unit: RTL and testbench
===================================

Name: icache_fill_unit

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction fetch port and a multi-cycle instruction memory.
- On a hit, returns the instruction word in the same cycle.
- On a miss, stalls the core and refills one full line over a request/beat handshake with the backing memory.
- Exposes a stall output that the pipeline controller uses to hold the IF stage.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk  input  1  main clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inst_ren  input  1  core instruction read enable.
- inst_addr  input  32  core fetch byte address; bits [1:0] ignored.
- inst_data  output  32  instruction word; valid when inst_ren=1 and inst_stall=0.
- inst_stall  output  1  core must hold inst_addr/inst_ren while high.
- flush  input  1  invalidate all lines; single-cycle pulse.
- mem_req  output  1  line refill request.
- mem_addr  output  32  line-aligned refill address.
- mem_ack  input  1  memory accepts request.
- mem_rvalid  input  1  one refill beat on mem_rdata.
- mem_rdata  input  32  refill word, delivered in ascending word order.
- miss_cnt  output  16  count of refills completed; wraps modulo 2^16.

Behaviour:
- Clock/reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - all valid bits 0; FSM IDLE; beat counter 0; miss_cnt 0.
  - mem_req 0; mem_addr 0; inst_stall 0; inst_data 0.
  - Tag/data arrays are not reset.
- Address split (OFF=log2(LINE_WORDS), IDX=log2(LINES)):
  - word offset inst_addr[OFF+1:2]
  - index inst_addr[OFF+IDX+1:OFF+2]
  - tag the remaining upper bits.
- Hit = inst_ren & valid[index] & (tag_array[index]==tag). Combinational.
- inst_data:
  - data_array[index][offset] when state IDLE and hit.
  - Otherwise 0.
- inst_stall:
  - In IDLE: inst_ren & ~hit.
  - In REQ, FILL and DONE: always 1.
  - Asserted combinationally, so a miss never presents a wrong word with stall low.
- FSM:
  - IDLE:
    - inst_ren & ~hit & ~flush: latch miss address into mem_addr with offset and [1:0] zeroed; go REQ.
    - inst_ren=0: no action.
  - REQ:
    - mem_req=1, mem_addr held.
    - On mem_ack: mem_req drops next cycle; beat counter=0; go FILL.
    - mem_ack may arrive in the same cycle mem_req first rises.
  - FILL:
    - Each mem_rvalid writes mem_rdata into data_array[latched index][beat] and increments beat.
    - Cycles without mem_rvalid are legal idle gaps.
    - On the beat with beat==LINE_WORDS-1:
      - write tag; set valid unless flush_pend; miss_cnt+1; go DONE.
  - DONE:
    - One cycle; clear flush_pend; go IDLE.
    - Next cycle re-evaluates the hit, so a refill costs at least 2 + LINE_WORDS cycles of stall.
- mem_rvalid outside FILL is ignored. mem_ack outside REQ is ignored.
- Flush:
  - In IDLE or DONE: clears all valid bits at the next edge.
  - In REQ or FILL: clears all valid bits and sets flush_pend. The refill still completes, but its line is left invalid, so the core re-misses.
  - flush in the same cycle as an IDLE miss: flush wins; no refill starts this cycle.
- Core changing inst_addr while stalled is a protocol violation. The refill uses the latched address.
- rst_n asserted mid-refill:
  - Immediate return to IDLE with all valid bits cleared and mem_req=0.
  - Any in-flight memory beats after release are ignored.
- miss_cnt increments only on completed refills and wraps 0xFFFF→0x0000.

Test Plan:
- Cold miss:
  - Stimulus: after reset, inst_ren=1, inst_addr=0x0000_0104; memory acks after 2 cycles and returns 0xA0,0xA1,0xA2,0xA3 back-to-back.
  - Response: mem_addr=0x0000_0100; stall high for exactly 2+4+2 cycles from first request; then inst_data=0xA1, stall=0, miss_cnt=1.
- Hit after fill:
  - Stimulus: same line, addresses 0x100/0x108/0x10C on consecutive cycles.
  - Response: data 0xA0/0xA2/0xA3 with stall=0 every cycle; mem_req stays 0.
- Conflict miss:
  - Stimulus: 0x0000_0200 after the above (same index 0, new tag).
  - Response: refill at mem_addr 0x200; 0x100 then misses again; miss_cnt=3.
- Gapped beats:
  - Stimulus: mem_rvalid pattern 1,0,0,1,1,0,1.
  - Response: all 4 words land at correct offsets; stall ends 2 cycles after the last beat.
- Flush during FILL:
  - Stimulus: flush pulse after beat 1.
  - Response: refill finishes, miss_cnt increments, line invalid; the following cycle re-misses (mem_req=1 again).
- Reset mid-refill:
  - Stimulus: rst_n low in FILL.
  - Response: asynchronously mem_req=0, inst_stall=0, miss_cnt=0; after release, a fetch of 0x104 misses.

Source files
------------

// File: rtl/icache_fill_unit.sv
// Direct-mapped, read-only instruction cache with a line refill engine.
// Hits return the word combinationally. A miss stalls the core while one
// full line is fetched over a request/beat handshake.
//
// Memory handshake: mem_req stays high, with mem_addr held, until a cycle
// where mem_ack is also high. After that, every cycle with mem_rvalid high
// carries one word, in ascending order, until the line is full. mem_ack
// outside the request phase is ignored. mem_rvalid outside the fill phase
// is ignored.
module icache_fill_unit #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        inst_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_cnt,
  output logic [1:0]  dbg_state
);

  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 32 - OFF - IDX - 2;
  localparam logic [OFF-1:0] LAST_BEAT = OFF'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [LINES-1:0] r_valid;
  logic             r_flush_pend;
  logic [OFF-1:0]   r_beat;
  logic [15:0]      r_miss_cnt;
  logic             r_mem_req;
  logic [31:0]      r_mem_addr;
  logic [IDX-1:0]   r_idx;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_tag_arr [0:LINES-1];
  logic [31:0]      r_data    [0:LINES*LINE_WORDS-1];

  logic [OFF-1:0]   w_off;
  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_beat_we;
  logic             w_last;
  logic             w_unused;

  // Fetch address split into word offset, line index and tag
  assign w_off    = inst_addr[OFF+1:2];
  assign w_idx    = inst_addr[OFF+IDX+1:OFF+2];
  assign w_tag    = inst_addr[31:OFF+IDX+2];
  assign w_unused = ^inst_addr[1:0];

  assign w_hit     = inst_ren & r_valid[w_idx] & (r_tag_arr[w_idx] == w_tag);
  assign w_beat_we = (r_state == S_FILL) & mem_rvalid;
  assign w_last    = w_beat_we & (r_beat == LAST_BEAT);

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign miss_cnt  = r_miss_cnt;
  assign dbg_state = r_state;

  // Tag and data arrays: written only by refill beats, never reset
  always_ff @(posedge clk) begin
    if (w_beat_we) begin
      r_data[{r_idx, r_beat}] <= mem_rdata;
    end
    if (w_last) begin
      r_tag_arr[r_idx] <= r_tag;
    end
  end

  // Refill FSM, valid bits, flush tracking and miss counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_beat       <= '0;
      r_miss_cnt   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_idx        <= '0;
      r_tag        <= '0;
    end else begin
      // A flush always wipes every line. A refill still in flight keeps
      // going but must not mark its line valid afterwards.
      if (flush) begin
        r_valid <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (!flush && inst_ren && !w_hit) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {inst_addr[31:OFF+2], {(OFF+2){1'b0}}};
            r_idx      <= w_idx;
            r_tag      <= w_tag;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_beat    <= '0;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) begin
            r_flush_pend <= 1'b1;
          end
          if (w_beat_we) begin
            r_beat <= r_beat + 1'b1;
            if (w_last) begin
              if (!(r_flush_pend || flush)) begin
                r_valid[r_idx] <= 1'b1;
              end
              r_miss_cnt <= r_miss_cnt + 16'd1;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Hit path: word out and stall are combinational, so a miss never shows
  // a stale word with stall low
  always_comb begin
    inst_data  = '0;
    inst_stall = 1'b1;
    if (r_state == S_IDLE) begin
      inst_stall = inst_ren & ~w_hit;
      if (w_hit) begin
        inst_data = r_data[{w_idx, w_off}];
      end
    end
  end

endmodule

// File: tb/tb_icache_fill_unit.sv
// Bench for icache_fill_unit: table of fetches served by a bench memory
// model, plus hand-written flush and reset corner cases.
`timescale 1ns/1ps
module tb_icache_fill_unit;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        inst_ren   = 1'b0;
  logic [31:0] inst_addr  = '0;
  logic        flush      = 1'b0;
  logic        mem_ack    = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic [31:0] inst_data;
  logic        inst_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [15:0] miss_cnt;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    int          ack_dly;
    logic [7:0]  vpat;
    int          plen;
    int          exp_stall;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vt [0:12];

  icache_fill_unit #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .inst_stall (inst_stall),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .miss_cnt   (miss_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Backing memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h10) return 32'hA0 + {30'h0, a[3:2]};
    return {a[31:2], 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one fetch and act as the memory until the core is released.
  // Expected word goes into exp_q when the fetch is driven and is popped
  // when stall drops.
  task automatic do_fetch(input string name, input logic [31:0] addr, input int ack_dly,
                          input logic [7:0] vpat, input int plen, input int exp_stall,
                          input logic [15:0] exp_cnt);
    int         stall_cyc = 0;
    int         req_cyc   = 0;
    int         pat_i     = 0;
    bit         acked     = 0;
    bit         done      = 0;
    logic [1:0] beat      = 2'd0;
    logic [31:0] exp_w;
    exp_q.push_back(mem_word(addr));
    @(negedge clk);
    inst_ren  = 1'b1;
    inst_addr = addr;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      if (!inst_stall) begin
        done = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s_sb: got output with empty expected queue", name);
        end else begin
          exp_w = exp_q.pop_front();
          chk($sformatf("%s_data", name), inst_data, exp_w);
        end
        chk($sformatf("%s_req_low", name), {31'h0, mem_req}, 32'h0);
      end else begin
        stall_cyc++;
        if (acked) begin
          if (pat_i < plen && vpat[pat_i]) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word({addr[31:4], beat, 2'b00});
            beat++;
          end
          pat_i++;
        end else if (mem_req) begin
          req_cyc++;
          if (req_cyc == 1) chk($sformatf("%s_mem_addr", name), mem_addr, {addr[31:4], 4'h0});
          if (req_cyc >= ack_dly) begin
            mem_ack = 1'b1;
            acked   = 1;
          end
        end
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: stall still 1 after 64 cycles, expected release", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    chk($sformatf("%s_stall_cycles", name), stall_cyc, exp_stall);
    chk($sformatf("%s_miss_cnt", name), {16'h0, miss_cnt}, {16'h0, exp_cnt});
  endtask

  initial begin
    // Fetch table: hits use ack_dly/vpat of zero and expect no stall
    vt[0]  = '{32'h0000_0104, 2, 8'h0F, 4, 8,  16'd1};
    vt[1]  = '{32'h0000_0100, 0, 8'h00, 0, 0,  16'd1};
    vt[2]  = '{32'h0000_0108, 0, 8'h00, 0, 0,  16'd1};
    vt[3]  = '{32'h0000_010C, 0, 8'h00, 0, 0,  16'd1};
    vt[4]  = '{32'h0000_0200, 2, 8'h0F, 4, 8,  16'd2};
    vt[5]  = '{32'h0000_0100, 2, 8'h0F, 4, 8,  16'd3};
    vt[6]  = '{32'h0000_0204, 1, 8'h59, 7, 10, 16'd4};
    vt[7]  = '{32'h0000_0200, 0, 8'h00, 0, 0,  16'd4};
    vt[8]  = '{32'h0000_0208, 0, 8'h00, 0, 0,  16'd4};
    vt[9]  = '{32'h0000_020C, 0, 8'h00, 0, 0,  16'd4};
    vt[10] = '{32'h0000_03F4, 1, 8'h0F, 4, 7,  16'd5};
    vt[11] = '{32'h0000_03F8, 0, 8'h00, 0, 0,  16'd5};
    vt[12] = '{32'h0000_0104, 3, 8'h0F, 4, 9,  16'd6};

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_stall", {31'h0, inst_stall}, 32'h0);
    chk("rst_req", {31'h0, mem_req}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_cnt", {16'h0, miss_cnt}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_req", {31'h0, mem_req}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      do_fetch($sformatf("vec%0d", i), vt[i].addr, vt[i].ack_dly, vt[i].vpat,
               vt[i].plen, vt[i].exp_stall, vt[i].exp_cnt);
    end

    // Flush in the same cycle as an idle miss: no refill starts
    @(negedge clk); inst_ren = 1'b1; inst_addr = 32'h0000_0600; flush = 1'b1; #1;
    chk("flushmiss_stall", {31'h0, inst_stall}, 32'h1);
    @(negedge clk); flush = 1'b0; #1;
    chk("flushmiss_no_req", {31'h0, mem_req}, 32'h0);
    chk("flushmiss_state", {30'h0, dbg_state}, 32'h0);
    do_fetch("flushmiss_fill", 32'h0000_0600, 1, 8'h0F, 4, 6, 16'd7);
    do_fetch("flushed_line", 32'h0000_03F4, 2, 8'h0F, 4, 8, 16'd8);

    // Flush after beat 1 of a refill: line completes but stays invalid
    @(negedge clk); inst_ren = 1'b1; inst_addr = 32'h0000_0500; #1;
    chk("ffill_stall", {31'h0, inst_stall}, 32'h1);
    @(negedge clk); #1;
    chk("ffill_req", {31'h0, mem_req}, 32'h1);
    chk("ffill_addr", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; #1;
    mem_rvalid = 1'b1; mem_rdata = mem_word(32'h0000_0500);
    @(negedge clk); #1;
    mem_rdata = mem_word(32'h0000_0504);
    @(negedge clk); #1;
    mem_rvalid = 1'b0; flush = 1'b1;
    @(negedge clk); #1;
    flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = mem_word(32'h0000_0508);
    @(negedge clk); #1;
    mem_rdata = mem_word(32'h0000_050C);
    @(negedge clk); #1;
    mem_rvalid = 1'b0;
    chk("ffill_done_state", {30'h0, dbg_state}, 32'h3);
    chk("ffill_done_stall", {31'h0, inst_stall}, 32'h1);
    chk("ffill_cnt", {16'h0, miss_cnt}, 32'd9);
    @(negedge clk); #1;
    chk("ffill_remiss_state", {30'h0, dbg_state}, 32'h0);
    chk("ffill_remiss_stall", {31'h0, inst_stall}, 32'h1);
    chk("ffill_remiss_data", inst_data, 32'h0);
    do_fetch("ffill_refetch", 32'h0000_0500, 1, 8'h0F, 4, 6, 16'd10);

    // Reset in the middle of a refill
    @(negedge clk); inst_ren = 1'b1; inst_addr = 32'h0000_0104; #1;
    @(negedge clk); #1;
    chk("rstfill_req", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; #1;
    mem_rvalid = 1'b1; mem_rdata = mem_word(32'h0000_0100);
    @(negedge clk); #1;
    chk("rstfill_state", {30'h0, dbg_state}, 32'h2);
    mem_rdata = mem_word(32'h0000_0104);
    @(negedge clk); #1;
    rst_n = 1'b0; inst_ren = 1'b0;
    mem_rdata = mem_word(32'h0000_0108);
    #1;
    chk("rstfill_req_low", {31'h0, mem_req}, 32'h0);
    chk("rstfill_stall_low", {31'h0, inst_stall}, 32'h0);
    chk("rstfill_cnt", {16'h0, miss_cnt}, 32'h0);
    chk("rstfill_idle", {30'h0, dbg_state}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    mem_rdata = mem_word(32'h0000_010C);
    repeat (2) @(negedge clk);
    #1;
    mem_rvalid = 1'b0;
    chk("rstfill_beats_ignored_state", {30'h0, dbg_state}, 32'h0);
    chk("rstfill_beats_ignored_cnt", {16'h0, miss_cnt}, 32'h0);
    do_fetch("rst_refetch", 32'h0000_0104, 2, 8'h0F, 4, 8, 16'd1);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_drain: %0d expected words never produced, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
